// File: rtl/msrh_ldq_pick_sched.sv
// Load-queue issue scheduler: oldest-first pick per LSU pipe using an allocation-order
// age matrix, with a registered issue slot per pipe feeding EX0.
module msrh_ldq_pick_sched #(
   parameter int unsigned ENTRY_SIZE = 16,
   parameter int unsigned PIPE_NUM   = 2
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [ENTRY_SIZE-1:0]          i_disp_valid,
   input  logic [ENTRY_SIZE-1:0]          i_entry_finish,
   input  logic [ENTRY_SIZE-1:0]          i_entry_ready,
   input  logic [ENTRY_SIZE*PIPE_NUM-1:0] i_entry_pipe_oh,
   input  logic [PIPE_NUM-1:0]            i_pipe_stall,
   input  logic                           i_flush,
   output logic [ENTRY_SIZE-1:0]          o_entry_picked,
   output logic [PIPE_NUM-1:0]            o_issue_valid,
   output logic [ENTRY_SIZE*PIPE_NUM-1:0] o_issue_idx_oh
);

   logic [ENTRY_SIZE-1:0] r_valid;
   logic [ENTRY_SIZE-1:0] w_keep;
   logic [ENTRY_SIZE-1:0] r_older     [ENTRY_SIZE];
   logic [ENTRY_SIZE-1:0] w_older_nxt [ENTRY_SIZE];

   logic [PIPE_NUM-1:0][ENTRY_SIZE-1:0] w_cand;
   logic [PIPE_NUM-1:0][ENTRY_SIZE-1:0] w_pick_raw;
   logic [PIPE_NUM-1:0][ENTRY_SIZE-1:0] w_pick;
   logic [PIPE_NUM-1:0]                 w_accept;
   logic [PIPE_NUM-1:0]                 w_issue_valid_nxt;
   logic [PIPE_NUM-1:0][ENTRY_SIZE-1:0] w_issue_idx_nxt;
   logic [ENTRY_SIZE-1:0][PIPE_NUM-1:0] w_picked_t;
   logic [ENTRY_SIZE-1:0]               w_picked;

   assign w_keep = r_valid & ~i_entry_finish;

   // Age matrix: older[i][j]=1 means j is older than i; lower index wins among same-cycle allocations
   for (genvar gi = 0; gi < ENTRY_SIZE; gi++) begin : g_row
      for (genvar gj = 0; gj < ENTRY_SIZE; gj++) begin : g_col
         if (gj < gi) begin : g_lo
            assign w_older_nxt[gi][gj] = i_disp_valid[gi] ? (w_keep[gj] | i_disp_valid[gj])
                                                          : (r_older[gi][gj] & ~i_disp_valid[gj]);
         end else begin : g_hi
            assign w_older_nxt[gi][gj] = i_disp_valid[gi] ? (w_keep[gj] & ~i_disp_valid[gj])
                                                          : (r_older[gi][gj] & ~i_disp_valid[gj]);
         end
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
         if (i_reset) begin
            r_older[gi] <= '0;
         end else begin
            r_older[gi] <= w_older_nxt[gi];
         end
      end
   end

   // Dispatch takes priority over finish on the same index
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_keep | i_disp_valid;
      end
   end

   for (genvar gp = 0; gp < PIPE_NUM; gp++) begin : g_pipe
      for (genvar ge = 0; ge < ENTRY_SIZE; ge++) begin : g_ent
         assign w_cand[gp][ge]     = r_valid[ge] & i_entry_ready[ge] & i_entry_pipe_oh[ge*PIPE_NUM+gp];
         assign w_pick_raw[gp][ge] = w_cand[gp][ge] & ~(|(w_cand[gp] & r_older[ge]));
         assign w_picked_t[ge][gp] = w_pick[gp][ge] & w_accept[gp];
      end

      // Lowest set bit survives, guarding against an inconsistent matrix
      assign w_pick[gp]   = w_pick_raw[gp] & (~w_pick_raw[gp] + ENTRY_SIZE'(1));
      assign w_accept[gp] = (|w_cand[gp]) & ~i_flush & ~(o_issue_valid[gp] & i_pipe_stall[gp]);

      assign w_issue_valid_nxt[gp] = i_flush ? 1'b0 :
                                     (o_issue_valid[gp] & i_pipe_stall[gp]) ? 1'b1 : w_accept[gp];
      assign w_issue_idx_nxt[gp]   = i_flush ? '0 :
                                     (o_issue_valid[gp] & i_pipe_stall[gp]) ?
                                        o_issue_idx_oh[gp*ENTRY_SIZE +: ENTRY_SIZE] : w_pick[gp];
   end

   for (genvar ge = 0; ge < ENTRY_SIZE; ge++) begin : g_pick_or
      assign w_picked[ge] = |w_picked_t[ge];
   end

   assign o_entry_picked = i_reset ? '0 : w_picked;

   // Issue slot per pipe, pipe p occupies idx bits [p*ENTRY_SIZE +: ENTRY_SIZE]
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_issue_valid  <= '0;
         o_issue_idx_oh <= '0;
      end else begin
         o_issue_valid  <= w_issue_valid_nxt;
         o_issue_idx_oh <= w_issue_idx_nxt;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         assert ($countones(o_entry_picked) <= int'(PIPE_NUM))
            else $fatal(1, "ldq pick: too many picked bits %h", o_entry_picked);
         assert ((i_entry_finish & ~r_valid) == '0)
            else $fatal(1, "ldq pick: finish on invalid entry %h", i_entry_finish & ~r_valid);
      end
   end

   for (genvar gp = 0; gp < PIPE_NUM; gp++) begin : g_chk
      always_ff @(posedge i_clk) begin
         if (!i_reset) begin
            assert ($onehot0(o_issue_idx_oh[gp*ENTRY_SIZE +: ENTRY_SIZE]))
               else $fatal(1, "ldq pick: issue idx not onehot0 on pipe %0d", gp);
         end
      end
   end
`endif

endmodule

// File: doc/msrh_ldq_pick_sched.md
Name: msrh_ldq_pick_sched

Overview:
Oldest-first issue scheduler for the load queue. Each cycle it selects, per LSU pipe, the oldest LDQ entry that is operand-ready and steered to that pipe. It returns a one-hot picked pulse to the entries and drives a registered issue slot into each LSU pipeline EX0. Age order is tracked with an allocation-order age matrix updated on dispatch and finish.

Parameters:
ENTRY_SIZE, 16, number of LDQ entries.
PIPE_NUM, 2, number of LSU pipes (equals LSU_INST_NUM).

Ports:
i_clk  in  1  clock.
i_reset  in  1  asynchronous, active-high reset.
i_disp_valid  in  ENTRY_SIZE  per-entry allocation strobe; may be multi-hot in one cycle.
i_entry_finish  in  ENTRY_SIZE  per-entry deallocation strobe (entry finish).
i_entry_ready  in  ENTRY_SIZE  entry is in issue-wait with all operands ready.
i_entry_pipe_oh  in  ENTRY_SIZE*PIPE_NUM  per-entry one-hot pipe select; entry e occupies bits [e*PIPE_NUM +: PIPE_NUM].
i_pipe_stall  in  PIPE_NUM  pipe p cannot accept its issue slot this cycle.
i_flush  in  1  commit/branch flush; kills in-flight issue slots.
o_entry_picked  out  ENTRY_SIZE  one-hot-per-pipe pick pulse back to the entries (combinational).
o_issue_valid  out  PIPE_NUM  registered issue slot valid.
o_issue_idx_oh  out  ENTRY_SIZE*PIPE_NUM  registered one-hot entry index per pipe.

Behaviour:
- Reset (async, i_reset=1):
  - r_valid = 0, age matrix = 0.
  - o_issue_valid = 0, o_issue_idx_oh = 0.
  - o_entry_picked = 0 while reset is asserted.
- Age matrix: older[i][j] = 1 means entry j is older than entry i. Diagonal is always 0.
- Allocation of entry i (i_disp_valid[i]):
  - Row i is loaded with (r_valid & ~i_entry_finish), OR'd with the same-cycle allocations at indices below i. Among simultaneous allocations, the lower index is older.
  - Column i is cleared in every row that is not being allocated that cycle.
  - r_valid[i] is set.
- Finish of entry i clears r_valid[i]. Finish and dispatch of the same index in the same cycle: dispatch wins, and the entry becomes the youngest.
- Candidate set for pipe p: cand_p[e] = r_valid[e] & i_entry_ready[e] & pipe_oh[e][p].
- Pick for pipe p: entry e such that cand_p[e] is set and no j satisfies cand_p[j] & older[e][j]. The result is at most one-hot. If the matrix were ever inconsistent, the lowest index wins.
- Accept for pipe p: accept_p = |cand_p & ~i_flush & ~(o_issue_valid[p] & i_pipe_stall[p]).
- o_entry_picked = OR over p of (pick_p & {ENTRY_SIZE{accept_p}}). It is asserted in the same cycle as the pick. The entry leaves the ready state the next cycle.
- Issue register, next cycle:
  - if i_flush: valid = 0.
  - else if o_issue_valid & stall: hold valid and idx.
  - else: valid = accept_p, idx = pick_p.
- Latency: ready to picked pulse is 0 cycles; ready to o_issue_valid is 1 cycle.
- An entry drives at most one pipe (pipe_oh is one-hot), so it cannot be picked twice in one cycle.
- An entry is never both ready and allocated in the same cycle. Any ready bit for an unallocated entry is masked by r_valid.
- Reset mid-operation clears everything immediately. The first pick is possible in the first cycle after deassertion, once entries are dispatched.
- Simulation-only checks ($fatal):
  - o_entry_picked has more than PIPE_NUM bits set.
  - an o_issue_idx_oh slice is not onehot0.
  - i_entry_finish is asserted on an invalid entry.

Test Plan:
- Reset, then dispatch entry 4 with ready=1 on pipe0 and no stall → o_entry_picked=0x0010 in the same cycle; next cycle o_issue_valid=2'b01, idx_oh[pipe0]=0x0010.
- Dispatch entry 5 at cycle 0 and entry 2 at cycle 1, both ready on pipe0 at cycle 3 → entry 5 picked first; entry 2 picked the cycle after entry 5 drops ready.
- Same-cycle dispatch of entries 7 and 3, both ready on pipe1 → entry 3 picked first.
- Entry 1 ready on pipe0 with o_issue_valid[0]=1 and i_pipe_stall[0]=1 for 3 cycles → o_entry_picked=0 and the slot is held; on stall release the slot updates to entry 1 and picked pulses once.
- Entry 6 ready on pipe0 and entry 9 ready on pipe1 in the same cycle → o_entry_picked=0x0240; both issue slots valid next cycle.
- Entry 0 finishes and is redispatched while entry 8 is valid, then both are ready on pipe0 → entry 8 picked first. Separately, i_flush with both slots valid → o_issue_valid=0 next cycle and no picked pulse in the flush cycle.
